ramio_ctrl: RTL and testbench
=============================

Name: ramio_ctrl

Overview:
- Downstream of the Core's RAMIO port: converts byte, half-word and word requests (write_type/read_type, byte address) into 32-bit word transactions with byte strobes on the backing memory (cache/BRAM).
- Handles lane steering, read sign/zero extension, and the busy/data_out_ready handshake the Core polls.
- Sole master of the memory port.

Parameters:
- ADDRESS_BITWIDTH, 32, byte-address width; memory word address is ADDRESS_BITWIDTH-2 bits.
- DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  request valid, held by the Core until it sees busy low.
- write_type  in  2  00 none, 01 byte, 10 half, 11 word.
- read_type  in  3  [1:0] as write_type; [2]=1 sign-extend.
- address  in  ADDRESS_BITWIDTH  byte address.
- data_in  in  DATA_WIDTH  write data, right-aligned.
- data_out  out  DATA_WIDTH  extended read result.
- data_out_ready  out  1  read result valid.
- busy  out  1  request in progress.
- fault  out  1  sticky unaligned-access flag.
- mem_req  out  1  memory request, level.
- mem_we  out  1  1 write, 0 read.
- mem_wstrb  out  4  byte-lane write enables.
- mem_addr  out  ADDRESS_BITWIDTH-2  word address.
- mem_wdata  out  32  lane-steered write data.
- mem_ack  in  1  one-cycle completion; mem_rdata valid for reads.
- mem_rdata  in  32  read word.

Behaviour:
- Reset: all outputs 0, state IDLE, armed=0.
- armed: set on any edge where enable=0; cleared on acceptance. This prevents a held enable from re-triggering.
- Acceptance: edge with state=IDLE, armed=1, enable=1 and (write_type!=0 or read_type[1:0]!=0).
  - Request fields are latched at acceptance.
  - A request with both types zero is ignored.
  - If both types are nonzero, write wins and the read is dropped.
- busy (combinational) = (state!=IDLE) or (enable & armed & type nonzero). It is therefore high in the same cycle the Core first drives enable.
- States:
  - IDLE -> BEAT0 on acceptance; mem_req=1 from the next cycle.
  - BEAT0: hold mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata stable until mem_ack; on mem_ack -> IDLE (or BEAT1, see optional feature).
  - Minimum latency: accept edge E0, mem_ack at E1, busy low after E1.
- Alignment: off=address[1:0]. A half-word is aligned when off is 0 or 2; a word is aligned when off=0; bytes are always aligned.
- Write steering:
  - byte: wstrb = 0001<<off, wdata = data_in[7:0] replicated to all lanes.
  - half: wstrb = 0011<<off, wdata = {2{data_in[15:0]}}.
  - word: wstrb = 1111.
- Read: lane = mem_rdata>>(8*off), masked to the access size. Sign-extended from bit 7/15 if read_type[2], else zero-extended. Word reads pass through unchanged.
- data_out/data_out_ready are registered on the completing mem_ack edge.
  - data_out_ready stays high until the next acceptance; it is cleared at acceptance.
  - data_out holds its value until the next completed read.
  - Writes never set data_out_ready.
- Unaligned access with the feature off:
  - No memory transaction.
  - Completes at the acceptance edge (busy low next cycle).
  - fault<=1; fault is cleared only by reset.
  - For a read: data_out_ready<=1 and data_out<=0.
- mem_ack is ignored outside BEAT0/BEAT1.
- rst_n low mid-transaction: mem_req drops asynchronously and the request is discarded. Memory may already have performed the write.

Optional Feature:
- Macro RAMIO_UNALIGNED_EN.
- When defined, unaligned half/word accesses split into two beats:
  - BEAT0 at word address[..:2]; BEAT1 at word address+1, wrapping to 0 at the top of the address space.
  - Writes: an 8-lane strobe = sizemask<<off, with data shifted by 8*off. The low 4 lanes go to BEAT0 and the high 4 to BEAT1. Beats with an all-zero strobe are still issued.
  - Reads: {rdata1, rdata0}>>(8*off) is then extended as normal.
  - busy spans both beats; fault is never set.
- When undefined: the fault behaviour above applies, and BEAT1 logic is absent.

Test Plan:
- Write word 0x44332211 at address 0x8 (mem_ack same cycle as mem_req) -> one beat with mem_addr=2, wstrb=1111, wdata=0x44332211; busy high for exactly 2 cycles.
- With word 0x80FF4120 at address 0x4:
  - unsigned half read at 0x4 -> data_out=0x00004120, data_out_ready=1.
  - signed byte read at 0x6 -> 0xFFFFFFFF.
  - signed half read at 0x6 -> 0xFFFF80FF.
- Byte write 0xAB at 0x7 -> wstrb=1000, wdata[31:24]=0xAB; a following word read of 0x4 returns 0xABFF4120.
- enable held high for 10 cycles after completion -> exactly one mem_req transaction; a second transaction occurs only after enable is low for 1 cycle.
- Half read at 0x3 without the macro -> no mem_req, fault=1, data_out=0. With the macro, and memory words 1=0x000000CD, 0=0xAB000000 -> two beats at addresses 0 then 1, data_out=0x0000CDAB.
- rst_n asserted while mem_req is waiting for ack (ack delayed 5 cycles) -> mem_req, busy and data_out_ready go to 0 immediately; a late mem_ack after reset is ignored.

Source files
------------

// File: rtl/ramio_ctrl.sv
// ramio_ctrl: converts the Core's byte/half/word RAMIO requests into 32-bit
// word transactions with byte strobes on the backing memory. It handles lane
// steering, sign/zero extension of reads and the busy/data_out_ready handshake.
// Build option RAMIO_UNALIGNED_EN: unaligned half/word accesses are split into
// two memory beats instead of raising the sticky fault flag.
module ramio_ctrl #(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [1:0]                  write_type,
    input  logic [2:0]                  read_type,
    input  logic [ADDRESS_BITWIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        data_out_ready,
    output logic                        busy,
    output logic                        fault,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [3:0]                  mem_wstrb,
    output logic [ADDRESS_BITWIDTH-3:0] mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_ack,
    input  logic [31:0]                 mem_rdata
);

    localparam int WA = ADDRESS_BITWIDTH - 2;
`ifdef RAMIO_UNALIGNED_EN
    localparam int LANES = 8;
`else
    localparam int LANES = 4;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
`ifdef RAMIO_UNALIGNED_EN
    localparam logic [1:0] S_BEAT1 = 2'd2;
`endif

    logic [1:0]         r_state;
    logic               r_armed;
    logic               r_is_wr;
    logic               r_sext;
    logic               r_dready;
    logic               r_fault;
    logic [1:0]         r_size;
    logic [1:0]         r_off;
    logic [WA-1:0]      r_addr;
    logic [LANES-1:0]   r_wstrb;
    logic [8*LANES-1:0] r_wdata;
    logic [31:0]        r_dout;
`ifdef RAMIO_UNALIGNED_EN
    logic               r_split;
    logic [31:0]        r_rdata0;
    logic [31:0]        w_masked;
`endif

    logic               w_wr;
    logic               w_rd;
    logic               w_accept;
    logic               w_aligned;
    logic               w_done;
    logic [1:0]         w_size;
    logic [1:0]         w_off;
    logic [LANES-1:0]   w_mask;
    logic [LANES-1:0]   w_strb;
    logic [31:0]        w_rep;
    logic [8*LANES-1:0] w_wdata;
    logic [31:0]        w_lane;

    // Extend a right-aligned lane to 32 bits according to access size.
    function automatic logic [31:0] extend(input logic [31:0] lane,
                                           input logic [1:0]  size,
                                           input logic        sext);
        case (size)
            2'd1:    extend = {{24{sext & lane[7]}}, lane[7:0]};
            2'd2:    extend = {{16{sext & lane[15]}}, lane[15:0]};
            default: extend = lane;
        endcase
    endfunction

    // Request decode, acceptance, write steering and read lane selection.
    always_comb begin
        w_wr     = |write_type;
        w_rd     = |read_type[1:0];
        // A write wins over a simultaneous read.
        w_size   = w_wr ? write_type : read_type[1:0];
        w_off    = address[1:0];
        case (w_size)
            2'd1:    w_aligned = 1'b1;
            2'd2:    w_aligned = ~w_off[0];
            default: w_aligned = (w_off == 2'd0);
        endcase
        w_accept = (r_state == S_IDLE) & r_armed & enable & (w_wr | w_rd);
        busy     = (r_state != S_IDLE) | (enable & r_armed & (w_wr | w_rd));
        case (w_size)
            2'd1:    w_mask = LANES'(1);
            2'd2:    w_mask = LANES'(3);
            default: w_mask = LANES'(15);
        endcase
        w_strb   = w_mask << w_off;
        case (w_size)
            2'd1:    w_rep = {4{data_in[7:0]}};
            2'd2:    w_rep = {2{data_in[15:0]}};
            default: w_rep = data_in;
        endcase
`ifdef RAMIO_UNALIGNED_EN
        case (w_size)
            2'd1:    w_masked = {24'd0, data_in[7:0]};
            2'd2:    w_masked = {16'd0, data_in[15:0]};
            default: w_masked = data_in;
        endcase
        // Unaligned data spans both beats: low word to BEAT0, high word to BEAT1.
        w_wdata  = w_aligned ? {32'd0, w_rep} : ({32'd0, w_masked} << {w_off, 3'b000});
        w_lane   = 32'(((r_state == S_BEAT1) ? {mem_rdata, r_rdata0} : {32'd0, mem_rdata})
                       >> {r_off, 3'b000});
        w_done   = mem_ack & (((r_state == S_BEAT0) & ~r_split) | (r_state == S_BEAT1));
`else
        w_wdata  = w_rep;
        w_lane   = mem_rdata >> {r_off, 3'b000};
        w_done   = mem_ack & (r_state == S_BEAT0);
`endif
    end

    // Control FSM, request latch and registered read result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_armed  <= 1'b0;
            r_is_wr  <= 1'b0;
            r_sext   <= 1'b0;
            r_dready <= 1'b0;
            r_fault  <= 1'b0;
            r_size   <= 2'd0;
            r_off    <= 2'd0;
            r_addr   <= '0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
            r_dout   <= '0;
`ifdef RAMIO_UNALIGNED_EN
            r_split  <= 1'b0;
            r_rdata0 <= '0;
`endif
        end else begin
            // A held enable must drop for one edge before it can start another request.
            if (!enable) r_armed <= 1'b1;
            if (w_accept) begin
                r_armed  <= 1'b0;
                r_is_wr  <= w_wr;
                r_size   <= w_size;
                r_off    <= w_off;
                r_sext   <= read_type[2];
                r_addr   <= address[ADDRESS_BITWIDTH-1:2];
                r_wstrb  <= w_wr ? w_strb : '0;
                r_wdata  <= w_wdata;
                r_dready <= 1'b0;
`ifdef RAMIO_UNALIGNED_EN
                r_split  <= ~w_aligned;
                r_state  <= S_BEAT0;
`else
                if (w_aligned) begin
                    r_state <= S_BEAT0;
                end else begin
                    // Unaligned: no memory access, completes right here.
                    r_fault <= 1'b1;
                    if (!w_wr) begin
                        r_dready <= 1'b1;
                        r_dout   <= '0;
                    end
                end
`endif
            end
`ifdef RAMIO_UNALIGNED_EN
            if (mem_ack && (r_state == S_BEAT0) && r_split) begin
                r_rdata0 <= mem_rdata;
                r_state  <= S_BEAT1;
            end
`endif
            if (w_done) begin
                r_state <= S_IDLE;
                if (!r_is_wr) begin
                    r_dready <= 1'b1;
                    r_dout   <= extend(w_lane, r_size, r_sext);
                end
            end
        end
    end

    assign mem_req        = (r_state != S_IDLE);
    assign mem_we         = r_is_wr;
    assign data_out       = r_dout;
    assign data_out_ready = r_dready;
    assign fault          = r_fault;
`ifdef RAMIO_UNALIGNED_EN
    // Second beat targets the following word, wrapping at the top of memory.
    assign mem_addr  = (r_state == S_BEAT1) ? r_addr + WA'(1) : r_addr;
    assign mem_wstrb = (r_state == S_BEAT1) ? r_wstrb[7:4] : r_wstrb[3:0];
    assign mem_wdata = (r_state == S_BEAT1) ? r_wdata[63:32] : r_wdata[31:0];
`else
    assign mem_addr  = r_addr;
    assign mem_wstrb = r_wstrb;
    assign mem_wdata = r_wdata;
`endif

endmodule

// File: tb/tb_ramio_ctrl.sv
// Bench for ramio_ctrl: table of single requests against a small word memory
// model, plus hand-written sequences for held enable, ignored requests,
// unaligned access and reset in the middle of a transaction.
module tb_ramio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  write_type = 2'd0;
    logic [2:0]  read_type = 3'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    ramio_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .write_type(write_type), .read_type(read_type),
        .address(address), .data_in(data_in),
        .data_out(data_out), .data_out_ready(data_out_ready),
        .busy(busy), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [16];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          beats = 0;
    logic        inject = 1'b0;
    logic [29:0] b_addr [2];
    logic [3:0]  b_strb [2];
    logic [31:0] b_wdata [2];
    logic        b_we [2];

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];

    typedef struct packed {
        logic [1:0]  wt;
        logic [2:0]  rt;
        logic [31:0] addr;
        logic [31:0] din;
        logic [29:0] maddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] dout;
    } vec_t;

    vec_t tv [14];

    // Memory responder: acknowledges each beat after ack_delay idle cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (inject) begin
                mem_ack = 1'b1;
                inject  = 1'b0;
            end else if (mem_req) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt  = 0;
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[3:0]];
                    if (beats < 2) begin
                        b_addr[beats]  = mem_addr;
                        b_strb[beats]  = mem_wstrb;
                        b_wdata[beats] = mem_wdata;
                        b_we[beats]    = mem_we;
                    end
                    beats++;
                    if (mem_we)
                        for (int i = 0; i < 4; i++)
                            if (mem_wstrb[i]) mem[mem_addr[3:0]][8*i +: 8] = mem_wdata[8*i +: 8];
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, data_out);
        end else begin
            e = exp_q.pop_front();
            chk(name, data_out, e);
        end
    endtask

    // Drive one request and wait (bounded) for busy to fall; bc = cycles busy was seen high.
    task automatic do_req(input logic [1:0] wt, input logic [2:0] rt, input logic [31:0] a,
                          input logic [31:0] d, output int bc);
        @(negedge clk);
        write_type = wt;
        read_type  = rt;
        address    = a;
        data_in    = d;
        enable     = 1'b1;
        beats      = 0;
        #1;
        bc = 0;
        while (busy && bc < 40) begin
            bc++;
            @(negedge clk);
            #1;
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, bc);
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        enable     = 1'b0;
        write_type = 2'd0;
        read_type  = 3'd0;
        address    = 32'd0;
        data_in    = 32'd0;
    endtask

    initial begin
        int          bc;
        logic        is_wr;
        logic        held_busy;
        logic [31:0] last_rd;

        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[1] = 32'h80FF4120;
        last_rd = 32'd0;

        tv[0]  = '{2'd3, 3'b000, 32'h8, 32'h44332211, 30'd2, 4'hF, 32'h44332211, 32'h0};
        tv[1]  = '{2'd0, 3'b010, 32'h4, 32'h0,        30'd1, 4'h0, 32'h0,        32'h00004120};
        tv[2]  = '{2'd0, 3'b101, 32'h6, 32'h0,        30'd1, 4'h0, 32'h0,        32'hFFFFFFFF};
        tv[3]  = '{2'd0, 3'b110, 32'h6, 32'h0,        30'd1, 4'h0, 32'h0,        32'hFFFF80FF};
        tv[4]  = '{2'd1, 3'b000, 32'h7, 32'h000000AB, 30'd1, 4'h8, 32'hABABABAB, 32'h0};
        tv[5]  = '{2'd0, 3'b011, 32'h4, 32'h0,        30'd1, 4'h0, 32'h0,        32'hABFF4120};
        tv[6]  = '{2'd0, 3'b001, 32'h5, 32'h0,        30'd1, 4'h0, 32'h0,        32'h00000041};
        tv[7]  = '{2'd2, 3'b000, 32'h8, 32'h0000BEEF, 30'd2, 4'h3, 32'hBEEFBEEF, 32'h0};
        tv[8]  = '{2'd0, 3'b110, 32'h8, 32'h0,        30'd2, 4'h0, 32'h0,        32'hFFFFBEEF};
        tv[9]  = '{2'd0, 3'b011, 32'h8, 32'h0,        30'd2, 4'h0, 32'h0,        32'h4433BEEF};
        tv[10] = '{2'd0, 3'b101, 32'h9, 32'h0,        30'd2, 4'h0, 32'h0,        32'hFFFFFFBE};
        tv[11] = '{2'd0, 3'b010, 32'hA, 32'h0,        30'd2, 4'h0, 32'h0,        32'h00004433};
        tv[12] = '{2'd1, 3'b011, 32'hB, 32'h0000005A, 30'd2, 4'h8, 32'h5A5A5A5A, 32'h0};
        tv[13] = '{2'd0, 3'b011, 32'h8, 32'h0,        30'd2, 4'h0, 32'h0,        32'h5A33BEEF};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", {27'd0, busy, mem_req, data_out_ready, fault, mem_we}, 32'd0);
        chk("reset_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("reset_addr", {2'd0, mem_addr}, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        chk("reset_dout", data_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single aligned requests
        for (int i = 0; i < 14; i++) begin
            is_wr = (tv[i].wt != 2'd0);
            if (!is_wr) exp_q.push_back(tv[i].dout);
            do_req(tv[i].wt, tv[i].rt, tv[i].addr, tv[i].din, bc);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd2);
            chk($sformatf("v%0d_beats", i), 32'(beats), 32'd1);
            chk($sformatf("v%0d_mem_addr", i), {2'd0, b_addr[0]}, {2'd0, tv[i].maddr});
            chk($sformatf("v%0d_mem_we", i), {31'd0, b_we[0]}, {31'd0, is_wr});
            if (is_wr) begin
                chk($sformatf("v%0d_wstrb", i), {28'd0, b_strb[0]}, {28'd0, tv[i].strb});
                chk($sformatf("v%0d_wdata", i), b_wdata[0], tv[i].wdata);
                chk($sformatf("v%0d_ready", i), {31'd0, data_out_ready}, 32'd0);
                chk($sformatf("v%0d_dout_hold", i), data_out, last_rd);
            end else begin
                chk($sformatf("v%0d_ready", i), {31'd0, data_out_ready}, 32'd1);
                pop_chk($sformatf("v%0d_dout", i));
                last_rd = tv[i].dout;
            end
            release_req();
        end

        // Both types zero: ignored
        @(negedge clk);
        read_type = 3'b100;
        enable    = 1'b1;
        beats     = 0;
        #1;
        chk("zero_type_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("zero_type_beats", 32'(beats), 32'd0);
        release_req();

        // Held enable produces one transaction only
        exp_q.push_back(32'hABFF4120);
        do_req(2'd0, 3'b011, 32'h4, 32'h0, bc);
        pop_chk("hold_dout");
        held_busy = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            held_busy = held_busy | busy | mem_req;
        end
        chk("hold_beats", 32'(beats), 32'd1);
        chk("hold_busy", {31'd0, held_busy}, 32'd0);
        release_req();
        do_req(2'd0, 3'b011, 32'h4, 32'h0, bc);
        chk("rearm_beats", 32'(beats), 32'd1);
        chk("rearm_busy_cycles", 32'(bc), 32'd2);
        release_req();

`ifdef RAMIO_UNALIGNED_EN
        // Unaligned half read split over two beats
        mem[0] = 32'hAB000000;
        mem[1] = 32'h000000CD;
        do_req(2'd0, 3'b010, 32'h3, 32'h0, bc);
        chk("split_busy_cycles", 32'(bc), 32'd3);
        chk("split_beats", 32'(beats), 32'd2);
        chk("split_addr0", {2'd0, b_addr[0]}, 32'd0);
        chk("split_addr1", {2'd0, b_addr[1]}, 32'd1);
        chk("split_dout", data_out, 32'h0000CDAB);
        chk("split_fault", {31'd0, fault}, 32'd0);
        release_req();
`else
        // Unaligned half read faults without touching memory
        do_req(2'd0, 3'b010, 32'h3, 32'h0, bc);
        chk("unal_busy_cycles", 32'(bc), 32'd1);
        chk("unal_beats", 32'(beats), 32'd0);
        chk("unal_fault", {31'd0, fault}, 32'd1);
        chk("unal_ready", {31'd0, data_out_ready}, 32'd1);
        chk("unal_dout", data_out, 32'd0);
        release_req();
        do_req(2'd0, 3'b011, 32'h4, 32'h0, bc);
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        release_req();
`endif

        // Reset while waiting for a delayed ack
        ack_delay = 5;
        @(negedge clk);
        read_type = 3'b011;
        address   = 32'h8;
        enable    = 1'b1;
        beats     = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {29'd0, mem_req, busy, data_out_ready}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        enable    = 1'b0;
        read_type = 3'd0;
        address   = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        ack_delay = 0;
        @(negedge clk);
        inject = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("late_ack_ctrl", {29'd0, mem_req, busy, data_out_ready}, 32'd0);
        chk("late_ack_beats", 32'(beats), 32'd0);

        // Normal operation after reset
        exp_q.push_back(32'h5A33BEEF);
        do_req(2'd0, 3'b011, 32'h8, 32'h0, bc);
        chk("recover_busy_cycles", 32'(bc), 32'd2);
        pop_chk("recover_dout");
        release_req();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
